// File: rtl/opb_stage.sv
// Registered operand-B selector for the ID->EX boundary with a 2-entry skid buffer.
// Optional feature: define OPB_FWD_EN to build the rs2 forwarding compare/override.
module opb_stage #(
    parameter int DATA_W  = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2,
    parameter int ADDR_W  = 5,
    parameter int FWD_N   = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_flush,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [NUM_SRC*DATA_W-1:0] i_src_data,
    input  logic [SEL_W-1:0]          i_opb_sel,
    input  logic [ADDR_W-1:0]         i_rs2_addr,
    input  logic [FWD_N-1:0]          i_fwd_we,
    input  logic [FWD_N*ADDR_W-1:0]   i_fwd_addr,
    input  logic [FWD_N*DATA_W-1:0]   i_fwd_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [DATA_W-1:0]         o_opb,
    output logic                      o_fwd_hit
);

    logic [DATA_W-1:0] src_arr [NUM_SRC];
    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] opb_next;
    logic              hit_next;

    logic              main_valid_reg;
    logic [DATA_W-1:0] main_data_reg;
    logic              main_hit_reg;
    logic              skid_valid_reg;
    logic [DATA_W-1:0] skid_data_reg;
    logic              skid_hit_reg;

    logic accept;
    logic consume;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign src_arr[gi] = i_src_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Out-of-range selects fall back to source 0 (rs2).
    always_comb begin
        sel_data = src_arr[0];
        for (int k = 1; k < NUM_SRC; k++) begin
            if (i_opb_sel == SEL_W'(k)) begin
                sel_data = src_arr[k];
            end
        end
    end

`ifdef OPB_FWD_EN
    logic [FWD_N-1:0]  fwd_match;
    logic [DATA_W-1:0] fwd_arr [FWD_N];

    generate
        for (genvar gi = 0; gi < FWD_N; gi++) begin : g_fwd
            assign fwd_match[gi] = i_fwd_we[gi]
                                && (i_fwd_addr[gi*ADDR_W +: ADDR_W] == i_rs2_addr)
                                && (i_rs2_addr != '0);
            assign fwd_arr[gi]   = i_fwd_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Scan oldest-to-youngest so the lowest-index (youngest) match wins.
    always_comb begin
        opb_next = sel_data;
        hit_next = 1'b0;
        if (i_opb_sel == '0) begin
            for (int c = FWD_N - 1; c >= 0; c--) begin
                if (fwd_match[c]) begin
                    opb_next = fwd_arr[c];
                    hit_next = 1'b1;
                end
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{i_fwd_we, i_fwd_addr, i_fwd_data, i_rs2_addr};
    assign opb_next   = sel_data;
    assign hit_next   = 1'b0;
`endif

    assign accept  = i_valid && !skid_valid_reg;
    assign consume = main_valid_reg && i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            main_valid_reg <= 1'b0;
            main_data_reg  <= '0;
            main_hit_reg   <= 1'b0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_hit_reg   <= 1'b0;
        end else if (i_flush) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (!main_valid_reg || consume) begin
            // A held skid entry is older than anything new; o_ready is low while it is held.
            if (skid_valid_reg) begin
                main_valid_reg <= 1'b1;
                main_data_reg  <= skid_data_reg;
                main_hit_reg   <= skid_hit_reg;
                skid_valid_reg <= 1'b0;
            end else begin
                main_valid_reg <= accept;
                if (accept) begin
                    main_data_reg <= opb_next;
                    main_hit_reg  <= hit_next;
                end
            end
        end else if (accept) begin
            skid_valid_reg <= 1'b1;
            skid_data_reg  <= opb_next;
            skid_hit_reg   <= hit_next;
        end
    end

    assign o_ready   = !skid_valid_reg;
    assign o_valid   = main_valid_reg;
    assign o_opb     = main_data_reg;
    assign o_fwd_hit = main_hit_reg;

endmodule

// File: tb/tb_opb_stage.sv
// Self-checking bench for opb_stage: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_opb_stage;

    localparam int DATA_W  = 32;
    localparam int NUM_SRC = 3;
    localparam int SEL_W   = 2;
    localparam int ADDR_W  = 5;
    localparam int FWD_N   = 2;
`ifdef OPB_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      flush;
    logic                      in_valid;
    logic                      out_ready;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [SEL_W-1:0]          opb_sel;
    logic [ADDR_W-1:0]         rs2_addr;
    logic [FWD_N-1:0]          fwd_we;
    logic [FWD_N*ADDR_W-1:0]   fwd_addr;
    logic [FWD_N*DATA_W-1:0]   fwd_data;
    logic                      out_valid;
    logic                      down_ready;
    logic [DATA_W-1:0]         opb;
    logic                      fwd_hit;

    int checks = 0;
    int errors = 0;
    logic [DATA_W:0] exp_q[$];   // {fwd_hit, operand}, oldest first

    always #5 clk = ~clk;

    opb_stage #(
        .DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .ADDR_W(ADDR_W), .FWD_N(FWD_N)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(in_valid), .o_ready(out_ready),
        .i_src_data(src_data), .i_opb_sel(opb_sel), .i_rs2_addr(rs2_addr), .i_fwd_we(fwd_we),
        .i_fwd_addr(fwd_addr), .i_fwd_data(fwd_data), .o_valid(out_valid), .i_ready(down_ready),
        .o_opb(opb), .o_fwd_hit(fwd_hit)
    );

    function automatic logic [DATA_W:0] ref_opb(
        input logic [SEL_W-1:0]          sel,
        input logic [NUM_SRC*DATA_W-1:0] src,
        input logic [ADDR_W-1:0]         rs2,
        input logic [FWD_N-1:0]          we,
        input logic [FWD_N*ADDR_W-1:0]   fa,
        input logic [FWD_N*DATA_W-1:0]   fd
    );
        int idx;
        logic [DATA_W-1:0] val;
        logic hit;
        idx = (int'(sel) < NUM_SRC) ? int'(sel) : 0;
        val = src[idx*DATA_W +: DATA_W];
        hit = 1'b0;
        if (FWD_ON && sel == 0 && rs2 != 0) begin
            for (int c = 0; c < FWD_N; c++) begin
                if (!hit && we[c] && fa[c*ADDR_W +: ADDR_W] == rs2) begin
                    val = fd[c*DATA_W +: DATA_W];
                    hit = 1'b1;
                end
            end
        end
        return {hit, val};
    endfunction

    // Advance one clock and update the reference queue from the handshake seen before the edge.
    task automatic cycle();
        bit acc, cons, fl;
        logic [DATA_W:0] e;
        acc  = in_valid && out_ready;
        cons = out_valid && down_ready;
        fl   = flush;
        e    = ref_opb(opb_sel, src_data, rs2_addr, fwd_we, fwd_addr, fwd_data);
        @(posedge clk);
        #1;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (cons && exp_q.size() > 0) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(e);
        end
    endtask

    task automatic idle_inputs();
        flush      = 1'b0;
        in_valid   = 1'b0;
        down_ready = 1'b1;
        src_data   = '0;
        opb_sel    = '0;
        rs2_addr   = '0;
        fwd_we     = '0;
        fwd_addr   = '0;
        fwd_data   = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (opb !== '0) begin errors++; $display("FAIL reset_opb got %h exp 0", opb); end
        checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %b exp 0", fwd_hit); end
        checks++; if (out_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", out_ready); end
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_select();
        in_valid = 1'b1;
        opb_sel  = 2'd1;
        src_data = {32'h3333_3333, 32'h0000_0800, 32'h1111_1111};
        cycle();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sel_valid got %b exp 1", out_valid); end
        checks++; if (opb !== 32'h800) begin errors++; $display("FAIL sel_opb got %h exp 00000800", opb); end
        checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL sel_hit got %b exp 0", fwd_hit); end
        cycle();
    endtask

    task automatic test_forward();
        logic [DATA_W-1:0] exp_val;
        in_valid = 1'b1;
        opb_sel  = 2'd0;
        rs2_addr = 5'd5;
        src_data = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678};
        fwd_we   = 2'b11;
        fwd_addr = {5'd5, 5'd5};
        fwd_data = {32'h0000_1111, 32'hAAAA_0000};
        exp_val  = FWD_ON ? 32'hAAAA_0000 : 32'h1234_5678;
        cycle();
        in_valid = 1'b0;
        checks++; if (opb !== exp_val) begin errors++; $display("FAIL fwd_opb got %h exp %h", opb, exp_val); end
        checks++; if (fwd_hit !== FWD_ON) begin errors++; $display("FAIL fwd_hit got %b exp %b", fwd_hit, FWD_ON); end
        cycle();
    endtask

    task automatic test_x0();
        in_valid = 1'b1;
        opb_sel  = 2'd0;
        rs2_addr = 5'd0;
        src_data = {32'h3333_3333, 32'h2222_2222, 32'h0BAD_F00D};
        fwd_we   = 2'b01;
        fwd_addr = {5'd7, 5'd0};
        fwd_data = {32'h0, 32'hFFFF_FFFF};
        cycle();
        in_valid = 1'b0;
        checks++; if (opb !== 32'h0BAD_F00D) begin errors++; $display("FAIL x0_opb got %h exp 0badf00d", opb); end
        checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL x0_hit got %b exp 0", fwd_hit); end
        cycle();
        fwd_we = '0;
    endtask

    task automatic test_sel_range();
        in_valid = 1'b1;
        opb_sel  = 2'd3;
        rs2_addr = 5'd0;
        src_data = {32'h3333_3333, 32'h2222_2222, 32'hCAFE_F00D};
        cycle();
        in_valid = 1'b0;
        checks++; if (opb !== 32'hCAFE_F00D) begin errors++; $display("FAIL selrange_opb got %h exp cafef00d", opb); end
        cycle();
    endtask

    task automatic test_back_to_back();
        down_ready = 1'b0;
        in_valid   = 1'b1;
        opb_sel    = 2'd1;
        src_data   = {32'h0, 32'h0000_000A, 32'h0};
        cycle();
        checks++; if (opb !== 32'hA || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_a got %h/%b exp 0000000a/1", opb, out_valid); end
        src_data = {32'h0, 32'h0000_000B, 32'h0};
        cycle();
        checks++; if (out_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %b exp 0", out_ready); end
        src_data = {32'h0, 32'h0000_000C, 32'h0};
        cycle();
        checks++; if (opb !== 32'hA || out_ready !== 1'b0) begin errors++; $display("FAIL b2b_hold got %h/%b exp 0000000a/0", opb, out_ready); end
        down_ready = 1'b1;
        cycle();
        checks++; if (opb !== 32'hB || out_ready !== 1'b1) begin errors++; $display("FAIL b2b_b got %h/%b exp 0000000b/1", opb, out_ready); end
        cycle();
        in_valid = 1'b0;
        checks++; if (opb !== 32'hC || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_c got %h/%b exp 0000000c/1", opb, out_valid); end
        cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_flush();
        down_ready = 1'b0;
        in_valid   = 1'b1;
        opb_sel    = 2'd2;
        src_data   = {32'h0000_00D0, 32'h0, 32'h0};
        cycle();
        src_data   = {32'h0000_00E0, 32'h0, 32'h0};
        cycle();
        src_data   = {32'h0000_00F0, 32'h0, 32'h0};
        flush      = 1'b1;
        cycle();
        flush      = 1'b0;
        in_valid   = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", out_valid); end
        checks++; if (out_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", out_ready); end
        down_ready = 1'b1;
        cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_nodeliver got %b exp 0", out_valid); end
        // Flush while ready: the request offered in the flush cycle must be dropped too.
        down_ready = 1'b0;
        in_valid   = 1'b1;
        src_data   = {32'h0000_0A0A, 32'h0, 32'h0};
        cycle();
        src_data   = {32'h0000_0B0B, 32'h0, 32'h0};
        flush      = 1'b1;
        cycle();
        flush      = 1'b0;
        in_valid   = 1'b0;
        down_ready = 1'b1;
        checks++; if (out_valid !== 1'b0 || out_ready !== 1'b1) begin errors++; $display("FAIL flush2 got %b/%b exp 0/1", out_valid, out_ready); end
        cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush2_nodeliver got %b exp 0", out_valid); end
    endtask

    task automatic test_async_reset();
        down_ready = 1'b0;
        in_valid   = 1'b1;
        opb_sel    = 2'd1;
        src_data   = {32'h0, 32'h5555_AAAA, 32'h0};
        cycle();
        cycle();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", out_valid); end
        checks++; if (out_ready !== 1'b1) begin errors++; $display("FAIL arst_ready got %b exp 1", out_ready); end
        checks++; if (opb !== '0) begin errors++; $display("FAIL arst_opb got %h exp 0", opb); end
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        down_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            in_valid   = ($urandom_range(0, 9) < 6);
            down_ready = ($urandom_range(0, 9) < 5);
            flush      = ($urandom_range(0, 39) == 0);
            opb_sel    = SEL_W'($urandom_range(0, 3));
            rs2_addr   = ADDR_W'($urandom_range(0, 7));
            fwd_we     = FWD_N'($urandom);
            fwd_addr   = {ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7))};
            fwd_data   = {$urandom, $urandom};
            src_data   = {$urandom, $urandom, $urandom};
            checks++;
            if (out_valid !== (exp_q.size() > 0)) begin
                errors++; $display("FAIL rnd_valid n=%0d got %b exp %b", n, out_valid, exp_q.size() > 0);
            end
            checks++;
            if (out_ready !== (exp_q.size() < 2)) begin
                errors++; $display("FAIL rnd_ready n=%0d got %b exp %b", n, out_ready, exp_q.size() < 2);
            end
            if (exp_q.size() > 0) begin
                checks++;
                if ({fwd_hit, opb} !== exp_q[0]) begin
                    errors++; $display("FAIL rnd_opb n=%0d got %b/%h exp %b/%h", n, fwd_hit, opb, exp_q[0][DATA_W], exp_q[0][DATA_W-1:0]);
                end
            end
            cycle();
        end
        idle_inputs();
        for (int n = 0; n < 4; n++) begin
            if (exp_q.size() > 0) begin
                checks++;
                if ({fwd_hit, opb} !== exp_q[0] || out_valid !== 1'b1) begin
                    errors++; $display("FAIL drain_opb got %b/%h exp %b/%h", fwd_hit, opb, exp_q[0][DATA_W], exp_q[0][DATA_W-1:0]);
                end
            end
            cycle();
        end
        checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++; $display("FAIL drain_empty got valid=%b pending=%0d exp 0/0", out_valid, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_select();
        test_forward();
        test_x0();
        test_sel_range();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
